apb_led_pwm: RTL and testbench
==============================

APB_LED_PWM -- requirements
Module: apb_led_pwm

Interface
REQ-001 Parameter NUM_CH, default 8, number of PWM channels (1..8).
REQ-002 Parameter PRESC_W, default 16, prescaler width in bits.
REQ-003 io_systemClk  input  1  sole clock; all state rising-edge.
REQ-004 io_asyncResetn  input  1  reset, asynchronous, active-low.
REQ-005 io_apb_PSEL  input  1  APB select.
REQ-006 io_apb_PENABLE  input  1  APB access phase.
REQ-007 io_apb_PWRITE  input  1  1 = write, 0 = read.
REQ-008 io_apb_PADDR  input  16  byte address; only bits [5:0] decoded.
REQ-009 io_apb_PWDATA  input  32  write data.
REQ-010 io_apb_PRDATA  output  32  read data.
REQ-011 io_apb_PREADY  output  1  transfer complete.
REQ-012 io_apb_PSLVERROR  output  1  transfer error.
REQ-013 o_led  output  NUM_CH  PWM outputs.
REQ-014 o_irq  output  1  level interrupt.

Function
REQ-015 Register map:
- 0x00 CTRL: [0] EN, [1] IRQ_EN, [2] INV.
- 0x04 PRESC [PRESC_W-1:0].
- 0x08 PERIOD [7:0].
- 0x0C STATUS: [0] WRAP, write-1-to-clear.
- 0x10+4n DUTY[n] [7:0], n < NUM_CH.
- Unused bits read 0.
REQ-016 APB has zero wait states: PREADY = PSEL & PENABLE.
REQ-017 A write commits on the edge where PSEL & PENABLE & PWRITE & ~PSLVERROR.
REQ-018 PRDATA is combinational from the decoded address while PSEL & PENABLE & ~PWRITE, else 0.
REQ-019 PSLVERROR = PSEL & PENABLE & (PADDR[1:0] != 0 or address unmapped, including DUTY index >= NUM_CH).
REQ-020 An errored write changes no state.
REQ-021 Prescaler counter:
- Counts 0..PRESC while EN = 1.
- Emits a one-cycle tick when it equals PRESC, then returns to 0.
- PRESC = 0 gives a tick every cycle.
REQ-022 Period counter cnt[7:0] advances on each tick. At cnt == PERIOD_act with tick it wraps to 0, and that is the wrap event.
REQ-023 PERIOD and DUTY writes go to shadow registers, which read back the shadow value. Shadows copy into the active registers:
- at each wrap event, or
- on every cycle while EN = 0.
REQ-024 o_led[n] = EN & (cnt < DUTY_act[n]), XORed with INV.
- DUTY_act = 0 gives constant off.
- DUTY_act > PERIOD_act gives constant on.
REQ-025 While EN = 0, both the prescaler and cnt hold at 0. Setting EN restarts from cnt = 0 at the next edge.
REQ-026 Each wrap event sets WRAP. A W1C in the same cycle as a wrap leaves WRAP set (set wins).
REQ-027 o_irq = WRAP & IRQ_EN, registered-free combinational from the flops.
REQ-028 o_led is registered: it reflects cnt and DUTY_act one cycle after they change.

Reset
REQ-029 io_asyncResetn low clears immediately, mid-transfer or mid-period:
- all registers, shadows, actives, prescaler, cnt and o_led go to 0;
- o_irq goes to 0;
- PRDATA, PREADY and PSLVERROR go to 0.
REQ-030 Deassertion is used as received; the synchronizer is upstream.

Structure
REQ-031 A shared package holds the register offsets, CTRL bit indices and the STATUS WRAP index.
REQ-032 One sub-module, apb_led_pwm_tick, holds the prescaler and tick generation. The APB decode, registers, counter and comparators stay in the top.

Verification
REQ-033 Register access:
- Stimulus: write DUTY[3] = 0x40; read it back; read PADDR 0x02 and 0x40.
- Required: readback = 0x40, PSLVERROR = 0; both bad reads give PSLVERROR = 1 and change no state.
REQ-034 PWM waveform:
- Stimulus: PRESC = 0, PERIOD = 9, DUTY[0] = 3, EN = 1.
- Required: o_led[0] high 3 of every 10 cycles; WRAP sets each 10 cycles.
REQ-035 Shadow update:
- Stimulus: mid-period, write DUTY[0] = 7.
- Required: the current period keeps duty 3; the period after the next wrap shows 7 high cycles.
REQ-036 Boundaries:
- Stimulus: DUTY = 0, then DUTY = 0xFF with PERIOD = 9, then INV = 1.
- Required: constant 0, then constant 1, then both cases inverted.
REQ-037 Interrupt clear race:
- Stimulus: IRQ_EN = 1; issue a W1C STATUS on the exact wrap cycle.
- Required: o_irq stays 1; a later W1C with no wrap drops o_irq to 0.
REQ-038 Reset mid-operation:
- Stimulus: pull io_asyncResetn low mid-period with PRESC = 3.
- Required: o_led = 0 and o_irq = 0 without a clock edge; after release, all registers read 0.

Source files
------------

// File: rtl/apb_led_pwm_pkg.sv
// Shared definitions for the APB LED PWM block: register offsets, CTRL/STATUS
// bit positions and the CTRL register layout.
package apb_led_pwm_pkg;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 8;

    localparam logic [ADDR_W-1:0] OFS_CTRL   = 6'h00;
    localparam logic [ADDR_W-1:0] OFS_PRESC  = 6'h04;
    localparam logic [ADDR_W-1:0] OFS_PERIOD = 6'h08;
    localparam logic [ADDR_W-1:0] OFS_STATUS = 6'h0C;
    localparam logic [ADDR_W-1:0] OFS_DUTY0  = 6'h10;

    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_IRQ_EN = 1;
    localparam int unsigned CTRL_INV    = 2;

    localparam int unsigned STATUS_WRAP = 0;

    // CTRL register image, bit 0 at the bottom
    typedef struct packed {
        logic inv;
        logic irq_en;
        logic en;
    } ctrl_t;

endpackage

// File: rtl/apb_led_pwm_tick.sv
// Prescaler: counts 0..presc while enabled and pulses tick_c on the last count.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   en         : run enable; the counter is held at 0 while low
//   presc      : terminal count (0 gives a tick every cycle)
//   tick_c     : combinational one-cycle tick
module apb_led_pwm_tick #(
    parameter int unsigned PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick_c
);

    logic [PRESC_W-1:0] pcnt;

    // >= rather than == so a PRESC lowered below the running count still
    // terminates the current prescale interval instead of rolling over.
    assign tick_c = en & (pcnt >= presc);

    always_ff @(posedge clk or negedge rst_n) begin : presc_cnt
        if (!rst_n) begin
            pcnt <= '0;
        end else if (!en || tick_c) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/apb_led_pwm.sv
// APB-programmable multi-channel LED PWM with shadowed period/duty registers
// and a wrap interrupt.
// Ports:
//   io_systemClk, io_asyncResetn : clock, async active-low reset
//   io_apb_*                     : zero-wait-state APB slave (6-bit decode window)
//   o_led                        : registered PWM outputs, one per channel
//   o_irq                        : level interrupt, WRAP & IRQ_EN
module apb_led_pwm
    import apb_led_pwm_pkg::*;
#(
    parameter int unsigned NUM_CH  = 8,
    parameter int unsigned PRESC_W = 16
) (
    input  logic              io_systemClk,
    input  logic              io_asyncResetn,
    input  logic              io_apb_PSEL,
    input  logic              io_apb_PENABLE,
    input  logic              io_apb_PWRITE,
    input  logic [15:0]       io_apb_PADDR,
    input  logic [31:0]       io_apb_PWDATA,
    output logic [31:0]       io_apb_PRDATA,
    output logic              io_apb_PREADY,
    output logic              io_apb_PSLVERROR,
    output logic [NUM_CH-1:0] o_led,
    output logic              o_irq
);

    localparam int unsigned IDX_W = 4;

    logic              clk;
    logic              rst_n;
    assign clk   = io_systemClk;
    assign rst_n = io_asyncResetn;

    ctrl_t              ctrl;
    logic [PRESC_W-1:0] presc;
    logic [CNT_W-1:0]   period_sh;
    logic [CNT_W-1:0]   period_act;
    logic [CNT_W-1:0]   duty_sh  [NUM_CH];
    logic [CNT_W-1:0]   duty_act [NUM_CH];
    logic [CNT_W-1:0]   cnt;
    logic               wrap_flag;
    logic [NUM_CH-1:0]  led_q;

    logic [ADDR_W-1:0]  addr;
    logic [ADDR_W-1:0]  word_addr;
    logic [IDX_W-1:0]   duty_idx;
    logic               hi_bits;
    logic               misaligned;
    logic               is_duty;
    logic               mapped;
    logic               access_c;
    logic               err_c;
    logic               wr_c;
    logic               rd_c;
    logic               w1c_c;
    logic               tick_c;
    logic               wrap_c;
    logic [DATA_W-1:0]  rdata_c;
    logic               pwdata_unused;

    // Address decode; bits above the 64-byte window select nothing, so any
    // set upper bit is outside the register map.
    assign addr       = io_apb_PADDR[ADDR_W-1:0];
    assign word_addr  = {addr[ADDR_W-1:2], 2'b00};
    assign hi_bits    = |io_apb_PADDR[15:ADDR_W];
    assign misaligned = |addr[1:0];
    assign duty_idx   = addr[ADDR_W-1:2] - IDX_W'(OFS_DUTY0 >> 2);
    assign is_duty    = (word_addr >= OFS_DUTY0) && (duty_idx < IDX_W'(NUM_CH));
    assign mapped     = !hi_bits && ((word_addr == OFS_CTRL)   || (word_addr == OFS_PRESC) ||
                                     (word_addr == OFS_PERIOD) || (word_addr == OFS_STATUS) ||
                                     is_duty);

    // Bus handshake; gated by reset so the slave is silent while held in reset.
    assign access_c = rst_n & io_apb_PSEL & io_apb_PENABLE;
    assign err_c    = access_c & (misaligned | ~mapped);
    assign wr_c     = access_c & io_apb_PWRITE & ~err_c;
    assign rd_c     = access_c & ~io_apb_PWRITE & ~err_c;
    assign w1c_c    = wr_c && (word_addr == OFS_STATUS) && io_apb_PWDATA[STATUS_WRAP];

    assign io_apb_PREADY    = access_c;
    assign io_apb_PSLVERROR = err_c;
    assign io_apb_PRDATA    = rdata_c;

    assign pwdata_unused = ^io_apb_PWDATA;

    // Register writes (shadows for PERIOD/DUTY)
    always_ff @(posedge clk or negedge rst_n) begin : reg_write
        if (!rst_n) begin
            ctrl      <= '0;
            presc     <= '0;
            period_sh <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                duty_sh[n] <= '0;
            end
        end else if (wr_c) begin
            case (word_addr)
                OFS_CTRL: begin
                    ctrl.en     <= io_apb_PWDATA[CTRL_EN];
                    ctrl.irq_en <= io_apb_PWDATA[CTRL_IRQ_EN];
                    ctrl.inv    <= io_apb_PWDATA[CTRL_INV];
                end
                OFS_PRESC:  presc     <= io_apb_PWDATA[PRESC_W-1:0];
                OFS_PERIOD: period_sh <= io_apb_PWDATA[CNT_W-1:0];
                default: ;
            endcase
            for (int n = 0; n < NUM_CH; n++) begin
                if (is_duty && (duty_idx == IDX_W'(n))) begin
                    duty_sh[n] <= io_apb_PWDATA[CNT_W-1:0];
                end
            end
        end
    end

    // Read mux
    always_comb begin : read_mux
        rdata_c = '0;
        if (rd_c) begin
            case (word_addr)
                OFS_CTRL:   rdata_c = DATA_W'(ctrl);
                OFS_PRESC:  rdata_c = DATA_W'(presc);
                OFS_PERIOD: rdata_c = DATA_W'(period_sh);
                OFS_STATUS: rdata_c[STATUS_WRAP] = wrap_flag;
                default: begin
                    for (int n = 0; n < NUM_CH; n++) begin
                        if (is_duty && (duty_idx == IDX_W'(n))) begin
                            rdata_c = DATA_W'(duty_sh[n]);
                        end
                    end
                end
            endcase
        end
    end

    apb_led_pwm_tick #(
        .PRESC_W (PRESC_W)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (ctrl.en),
        .presc  (presc),
        .tick_c (tick_c)
    );

    assign wrap_c = ctrl.en & tick_c & (cnt == period_act);

    // Period counter and shadow-to-active transfer (every cycle while idle)
    always_ff @(posedge clk or negedge rst_n) begin : pwm_core
        if (!rst_n) begin
            cnt        <= '0;
            period_act <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                duty_act[n] <= '0;
            end
        end else begin
            if (!ctrl.en || wrap_c) begin
                cnt <= '0;
            end else if (tick_c) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (!ctrl.en || wrap_c) begin
                period_act <= period_sh;
                for (int n = 0; n < NUM_CH; n++) begin
                    duty_act[n] <= duty_sh[n];
                end
            end
        end
    end

    // WRAP status: a wrap in the same cycle as a W1C wins
    always_ff @(posedge clk or negedge rst_n) begin : wrap_status
        if (!rst_n) begin
            wrap_flag <= 1'b0;
        end else begin
            wrap_flag <= wrap_c | (wrap_flag & ~w1c_c);
        end
    end

    // Registered comparators
    always_ff @(posedge clk or negedge rst_n) begin : led_out
        if (!rst_n) begin
            led_q <= '0;
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                led_q[n] <= (ctrl.en & (cnt < duty_act[n])) ^ ctrl.inv;
            end
        end
    end

    assign o_led = led_q;
    assign o_irq = wrap_flag & ctrl.irq_en;

endmodule

// File: tb/tb_apb_led_pwm.sv
// Self-checking bench for apb_led_pwm: directed scenarios plus randomized
// register and PWM traffic against a period-level behavioural model.
module tb_apb_led_pwm;

    localparam int unsigned NUM_CH  = 8;
    localparam int unsigned PRESC_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [15:0]       paddr;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;
    logic [NUM_CH-1:0] led;
    logic              irq;

    int vectors     = 0;
    int miscompares = 0;
    int cycle_no    = 0;

    // Model state: the waveform is described by the elapsed cycle count
    // within the current period; cnt = slot / (PRESC + 1).
    bit                m_en, m_irq_en, m_inv, m_wrap;
    int                m_presc, m_period_sh, m_period_act, m_slot;
    int                m_duty_sh  [NUM_CH];
    int                m_duty_act [NUM_CH];
    logic [NUM_CH-1:0] m_led;

    logic [15:0] addr_tab [16] = '{16'h0000, 16'h0004, 16'h0008, 16'h000C,
                                   16'h0010, 16'h0014, 16'h0018, 16'h001C,
                                   16'h0020, 16'h0024, 16'h0028, 16'h002C,
                                   16'h0002, 16'h0030, 16'h0040, 16'h0101};

    apb_led_pwm #(
        .NUM_CH  (NUM_CH),
        .PRESC_W (PRESC_W)
    ) dut (
        .io_systemClk     (clk),
        .io_asyncResetn   (rst_n),
        .io_apb_PSEL      (psel),
        .io_apb_PENABLE   (penable),
        .io_apb_PWRITE    (pwrite),
        .io_apb_PADDR     (paddr),
        .io_apb_PWDATA    (pwdata),
        .io_apb_PRDATA    (prdata),
        .io_apb_PREADY    (pready),
        .io_apb_PSLVERROR (pslverr),
        .o_led            (led),
        .o_irq            (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit addr_err(input logic [15:0] a);
        int unsigned ai = 32'(a);
        if (ai % 4 != 0) return 1'b1;
        return !(ai < 16 + 4 * NUM_CH);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [15:0] a);
        int unsigned ai = 32'(a);
        if (addr_err(a)) return 32'h0;
        case (ai)
            0:       return {29'h0, m_inv, m_irq_en, m_en};
            4:       return 32'(m_presc);
            8:       return 32'(m_period_sh);
            12:      return {31'h0, m_wrap};
            default: return 32'(m_duty_sh[(ai - 16) / 4]);
        endcase
    endfunction

    task automatic model_reset();
        m_en = 0; m_irq_en = 0; m_inv = 0; m_wrap = 0;
        m_presc = 0; m_period_sh = 0; m_period_act = 0; m_slot = 0;
        m_led = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            m_duty_sh[n]  = 0;
            m_duty_act[n] = 0;
        end
    endtask

    // Advance the model by one clock edge using the bus values the DUT sampled.
    task automatic model_step();
        int   len, cnt, ai;
        bit   evt, wr, w1c;
        len = (m_period_act + 1) * (m_presc + 1);
        cnt = m_slot / (m_presc + 1);
        for (int n = 0; n < NUM_CH; n++) begin
            m_led[n] = (m_en && (cnt < m_duty_act[n])) ^ m_inv;
        end
        evt = m_en && (m_slot == len - 1);
        wr  = psel && penable && pwrite && !addr_err(paddr);
        ai  = int'(paddr);
        w1c = wr && (ai == 12) && pwdata[0];
        m_slot = (m_en && !evt) ? m_slot + 1 : 0;
        if (evt || !m_en) begin
            m_period_act = m_period_sh;
            for (int n = 0; n < NUM_CH; n++) m_duty_act[n] = m_duty_sh[n];
        end
        m_wrap = evt || (m_wrap && !w1c);
        if (wr) begin
            case (ai)
                0:  begin m_en = pwdata[0]; m_irq_en = pwdata[1]; m_inv = pwdata[2]; end
                4:  m_presc = int'(pwdata[PRESC_W-1:0]);
                8:  m_period_sh = int'(pwdata[7:0]);
                12: ;
                default: m_duty_sh[(ai - 16) / 4] = int'(pwdata[7:0]);
            endcase
        end
    endtask

    task automatic tick_cycle();
        @(posedge clk);
        model_step();
        cycle_no++;
        #1;
        check("led", 32'(led), 32'(m_led));
        check("irq", 32'(irq), 32'(m_wrap && m_irq_en));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick_cycle();
    endtask

    task automatic apb_write(input logic [15:0] a, input logic [31:0] d);
        psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
        tick_cycle();
        penable = 1;
        #1;
        check("wr_pready", 32'(pready), 32'd1);
        check("wr_pslverr", 32'(pslverr), 32'(addr_err(a)));
        check("wr_prdata", prdata, 32'h0);
        tick_cycle();
        psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic apb_read(input logic [15:0] a, output logic [31:0] d, output logic e);
        psel = 1; penable = 0; pwrite = 0; paddr = a;
        tick_cycle();
        penable = 1;
        #1;
        check("rd_pready", 32'(pready), 32'd1);
        check("rd_pslverr", 32'(pslverr), 32'(addr_err(a)));
        check("rd_prdata", prdata, exp_rd(a));
        d = prdata;
        e = pslverr;
        tick_cycle();
        psel = 0; penable = 0;
    endtask

    // Watch led[0] for n cycles: any = seen high, all = always high
    task automatic observe(input int n, output bit any, output bit all);
        any = 0; all = 1;
        for (int i = 0; i < n; i++) begin
            tick_cycle();
            any = any | led[0];
            all = all & led[0];
        end
    endtask

    task automatic wait_slot(input int s);
        for (int i = 0; i < 200 && m_slot != s; i++) tick_cycle();
    endtask

    task automatic wait_irq(output int t);
        t = -1;
        for (int i = 0; i < 40; i++) begin
            tick_cycle();
            if (irq === 1'b1) begin
                t = cycle_no;
                break;
            end
        end
        if (t < 0) check("irq_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        bit          any, all;
        int          t1, t2, hi, hi2, per, pre;

        // Reset: outputs quiet even with a live bus access pending
        rst_n = 0; psel = 1; penable = 1; pwrite = 0; paddr = 16'h0002; pwdata = '0;
        model_reset();
        #2;
        check("rst_led", 32'(led), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_pready", 32'(pready), 32'h0);
        check("rst_pslverr", 32'(pslverr), 32'h0);
        check("rst_prdata", prdata, 32'h0);
        psel = 0; penable = 0; paddr = '0;
        #20 rst_n = 1;
        tick_cycle();
        check("idle_pready", 32'(pready), 32'h0);

        // Register access and error decode
        apb_write(16'h001C, 32'h40);
        apb_read(16'h001C, d, e);
        check("duty3_rb", d, 32'h40);
        check("duty3_err", 32'(e), 32'h0);
        apb_read(16'h0002, d, e);
        check("err_0x02", 32'(e), 32'h1);
        apb_read(16'h0040, d, e);
        check("err_0x40", 32'(e), 32'h1);
        apb_write(16'h0042, 32'hFFFF_FFFF);
        apb_write(16'h0040, 32'h0000_0007);
        apb_write(16'h001E, 32'h0000_0011);
        apb_read(16'h001C, d, e);
        check("duty3_kept", d, 32'h40);
        apb_read(16'h0000, d, e);
        check("ctrl_kept", d, 32'h0);

        // Randomized register traffic with the PWM stopped
        for (int i = 0; i < 40; i++) begin
            logic [15:0] a;
            logic [31:0] wd;
            a  = addr_tab[$urandom_range(15, 0)];
            wd = $urandom;
            if (a == 16'h0000) wd[0] = 1'b0;
            if ($urandom_range(1, 0) == 1) apb_write(a, wd);
            else apb_read(a, d, e);
        end
        apb_write(16'h0000, 32'h0);

        // Basic waveform: 3 high of every 10, WRAP every 10 cycles
        apb_write(16'h0004, 32'd0);
        apb_write(16'h0008, 32'd9);
        apb_write(16'h0010, 32'd3);
        apb_write(16'h0000, 32'h3);
        run(25);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            tick_cycle();
            if (led[0]) hi++;
        end
        check("duty3_count", 32'(hi), 32'd6);
        wait_slot(0);
        apb_write(16'h000C, 32'h1);
        check("irq_cleared", 32'(irq), 32'h0);
        wait_irq(t1);
        apb_write(16'h000C, 32'h1);
        wait_irq(t2);
        check("wrap_interval", 32'(t2 - t1), 32'd10);

        // Shadow update: mid-period duty write takes effect after the wrap
        wait_slot(0);
        apb_write(16'h0010, 32'd7);
        hi = 2;
        for (int i = 0; i < 20; i++) begin
            tick_cycle();
            if (led[0]) hi++;
            else break;
        end
        check("cur_period_duty", 32'(hi), 32'd3);
        for (int i = 0; i < 20 && !led[0]; i++) tick_cycle();
        hi2 = 0;
        for (int i = 0; i < 20 && led[0]; i++) begin
            hi2++;
            tick_cycle();
        end
        check("next_period_duty", 32'(hi2), 32'd7);

        // Boundaries: duty 0, duty > period, then inverted
        apb_write(16'h0010, 32'd0);
        run(12);
        observe(20, any, all);
        check("duty0_off", 32'(any), 32'h0);
        apb_write(16'h0010, 32'hFF);
        run(12);
        observe(20, any, all);
        check("dutyff_on", 32'(all), 32'h1);
        apb_write(16'h0000, 32'h7);
        run(12);
        observe(20, any, all);
        check("dutyff_inv", 32'(any), 32'h0);
        apb_write(16'h0010, 32'd0);
        run(12);
        observe(20, any, all);
        check("duty0_inv", 32'(all), 32'h1);
        apb_write(16'h0000, 32'h3);
        apb_write(16'h0010, 32'd3);

        // W1C on the exact wrap cycle: set wins
        wait_slot(8);
        apb_write(16'h000C, 32'h1);
        check("irq_race_set", 32'(irq), 32'h1);
        apb_write(16'h000C, 32'h1);
        check("irq_w1c_clear", 32'(irq), 32'h0);

        // Randomized PWM configurations
        for (int k = 0; k < 3; k++) begin
            apb_write(16'h0000, 32'h0);
            pre = int'($urandom_range(3, 0));
            per = int'($urandom_range(20, 2));
            apb_write(16'h0004, 32'(pre));
            apb_write(16'h0008, 32'(per));
            for (int n = 0; n < NUM_CH; n++) begin
                int r = int'($urandom_range(5, 0));
                if (r == 0) apb_write(16'(16 + 4 * n), 32'd0);
                else if (r == 1) apb_write(16'(16 + 4 * n), 32'hFF);
                else apb_write(16'(16 + 4 * n), 32'($urandom_range(per + 1, 0)));
            end
            apb_write(16'h0000, {29'h0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'b1});
            run(2 * (per + 1) * (pre + 1));
            apb_write(16'(16 + 4 * $urandom_range(NUM_CH - 1, 0)), 32'($urandom_range(per + 1, 0)));
            apb_write(16'h0008, 32'($urandom_range(20, 2)));
            if ($urandom_range(1, 0) == 1) apb_write(16'h000C, 32'h1);
            run(3 * 21 * (pre + 1));
        end

        // Reset mid-period with PRESC = 3
        apb_write(16'h0000, 32'h0);
        apb_write(16'h0004, 32'd3);
        apb_write(16'h0008, 32'd9);
        apb_write(16'h0010, 32'hFF);
        apb_write(16'h0000, 32'h3);
        run(51);
        check("pre_rst_led0", 32'(led[0]), 32'h1);
        check("pre_rst_irq", 32'(irq), 32'h1);
        #2 rst_n = 0;
        #1;
        check("async_rst_led", 32'(led), 32'h0);
        check("async_rst_irq", 32'(irq), 32'h0);
        model_reset();
        @(posedge clk);
        #3 rst_n = 1;
        apb_read(16'h0000, d, e);
        check("post_rst_ctrl", d, 32'h0);
        apb_read(16'h0004, d, e);
        check("post_rst_presc", d, 32'h0);
        apb_read(16'h0008, d, e);
        check("post_rst_period", d, 32'h0);
        apb_read(16'h000C, d, e);
        check("post_rst_status", d, 32'h0);
        for (int n = 0; n < NUM_CH; n++) begin
            apb_read(16'(16 + 4 * n), d, e);
            check("post_rst_duty", d, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
